lag_prng: RTL and testbench



---
 rtl/lag_prng_pkg.sv | 37 +++
 rtl/lag_prng_if.sv | 27 ++
 rtl/lag_prng_core.sv | 53 +++++
 rtl/lag_prng.sv | 133 +++++++++++++
 tb/tb_lag_prng.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lag_prng_pkg.sv
// Shared types and pure helpers for the lagged shift-register word generator.
package lag_prng_pkg;

   // Widest word the helper functions support; wider instances are rejected at elaboration.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      ST_PRIME,
      ST_RUN,
      ST_SEED
   } state_e;

   function automatic logic [MAX_W-1:0] width_mask(input int w);
      logic [MAX_W-1:0] m;
      m = '1;
      if (w < MAX_W) m = (MAX_W'(1) << w) - MAX_W'(1);
      return m;
   endfunction

   // Default seed word i, truncated to w bits: z[0]=364, z[i]=i otherwise.
   function automatic logic [MAX_W-1:0] seed_default(input int i, input int w);
      logic [MAX_W-1:0] v;
      v = (i == 0) ? MAX_W'(364) : MAX_W'(i);
      return v & width_mask(w);
   endfunction

   // Next value of z[N-1]; operands arrive zero-extended so the right shift stays logical.
   function automatic logic [MAX_W-1:0] lag_step(input logic [MAX_W-1:0] z0,
                                                 input logic [MAX_W-1:0] z1,
                                                 input logic [MAX_W-1:0] zn2,
                                                 input int shl,
                                                 input int shr,
                                                 input int w);
      return (zn2 ^ (z1 << shl) ^ (z0 >> shr)) & width_mask(w);
   endfunction

endpackage

// File: rtl/lag_prng_if.sv
// Control, seeding and output-stream signals of the generator as one bundle.
interface lag_prng_if #(
   parameter int W     = 32,
   parameter int CNT_W = 32
);
   logic             seed_start;
   logic             seed_valid;
   logic [W-1:0]     seed_data;
   logic             seed_busy;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic [W-1:0]     out_tap;
   logic [CNT_W-1:0] gen_count;

   // Generator side.
   modport master (
      input  seed_start, seed_valid, seed_data, out_ready,
      output seed_busy, out_valid, out_data, out_tap, gen_count
   );

   // Consumer / seeding agent side.
   modport slave (
      output seed_start, seed_valid, seed_data, out_ready,
      input  seed_busy, out_valid, out_data, out_tap, gen_count
   );
endinterface

// File: rtl/lag_prng_core.sv
// State array z[0..N-1]: recurrence step, serial seed shift and default-seed reload.
module lag_prng_core
   import lag_prng_pkg::*;
#(
   parameter int W   = 32,
   parameter int N   = 4,
   parameter int SHL = W - 1,
   parameter int SHR = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         step_i,
   input  logic         seed_shift_i,
   input  logic         load_default_i,
   input  logic [W-1:0] seed_data_i,
   output logic [W-1:0] z0_o,
   output logic [W-1:0] zlast_o,
   output logic         all_zero_next_o
);

   logic [N-1:0][W-1:0] z_q, z_d;
   logic [W-1:0]        feedback;

   assign feedback = W'(lag_step(MAX_W'(z_q[0]), MAX_W'(z_q[1]), MAX_W'(z_q[N-2]),
                                 SHL, SHR, W));

   // A seed shift this cycle would leave the state all zero.
   assign all_zero_next_o = (seed_data_i == '0) && (z_q[N-1:1] == '0);

   assign z0_o    = z_q[0];
   assign zlast_o = z_q[N-1];

   always_comb begin
      // NOTE: default assignment first so every path assigns z_d and no latch is inferred.
      z_d = z_q;
      if (load_default_i) begin
         for (int i = 0; i < N; i++) z_d[i] = W'(seed_default(i, W));
      end else if (seed_shift_i || step_i) begin
         for (int i = 0; i < N - 1; i++) z_d[i] = z_q[i+1];
         z_d[N-1] = seed_shift_i ? seed_data_i : feedback;
      end
   end

   // NOTE: the state array resets to the default seed, not zero; an all-zero state never leaves zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) z_q[i] <= W'(seed_default(i, W));
      end else begin
         z_q <= z_d;
      end
   end

endmodule

// File: rtl/lag_prng.sv
// Lagged shift-register word generator: PRIME/RUN/SEED control, output stream and transfer count.
module lag_prng
   import lag_prng_pkg::*;
#(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int SHL   = W - 1,
   parameter int SHR   = 1,
   parameter int CNT_W = 32
) (
   input  logic       clock,
   input  logic       reset,
   lag_prng_if.master bus
);

   localparam int CW = $clog2(N) + 1;

   if (N < 3)       begin : g_bad_n   $error("lag_prng: N must be >= 3");        end
   if (W < 2)       begin : g_bad_w   $error("lag_prng: W must be >= 2");        end
   if (W > MAX_W)   begin : g_wide_w  $error("lag_prng: W exceeds MAX_W");       end
   if (SHL >= W)    begin : g_bad_shl $error("lag_prng: SHL must be < W");       end
   if (SHR >= W)    begin : g_bad_shr $error("lag_prng: SHR must be < W");       end

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    seed_cnt_q, seed_cnt_d;
   logic [W-1:0]     out_data_q, out_tap_q;
   logic [CNT_W-1:0] gen_count_q;

   logic             fire, seed_last;
   logic             step, capture, seed_shift, load_default, gen_inc;
   logic [W-1:0]     z0, zlast;
   logic             all_zero_next;

   lag_prng_core #(.W(W), .N(N), .SHL(SHL), .SHR(SHR)) u_core (
      .clock           (clock),
      .reset           (reset),
      .step_i          (step),
      .seed_shift_i    (seed_shift),
      .load_default_i  (load_default),
      .seed_data_i     (bus.seed_data),
      .z0_o            (z0),
      .zlast_o         (zlast),
      .all_zero_next_o (all_zero_next)
   );

   assign fire      = out_valid_q & bus.out_ready;
   assign seed_last = (seed_cnt_q == CW'(N - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_PRIME;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_PRIME: state_d = bus.seed_start ? ST_SEED : ST_RUN;
         ST_RUN:   if (bus.seed_start) state_d = ST_SEED;
         ST_SEED:  if (!bus.seed_start && bus.seed_valid && seed_last) state_d = ST_PRIME;
         default:  state_d = ST_PRIME;
      endcase
   end

   // seed_start outranks both a step and a seed word; a fire racing it still counts.
   always_comb begin
      step         = 1'b0;
      capture      = 1'b0;
      seed_shift   = 1'b0;
      load_default = 1'b0;
      gen_inc      = 1'b0;
      out_valid_d  = out_valid_q;
      seed_cnt_d   = seed_cnt_q;
      case (state_q)
         ST_PRIME: begin
            if (!bus.seed_start) begin
               capture     = 1'b1;
               step        = 1'b1;
               out_valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            gen_inc = fire;
            if (bus.seed_start) begin
               out_valid_d = 1'b0;
               seed_cnt_d  = '0;
            end else if (fire) begin
               capture = 1'b1;
               step    = 1'b1;
            end
         end
         ST_SEED: begin
            if (bus.seed_start) begin
               seed_cnt_d = '0;
            end else if (bus.seed_valid) begin
               seed_shift = 1'b1;
               if (seed_last) begin
                  load_default = all_zero_next;
                  seed_cnt_d   = '0;
               end else begin
                  seed_cnt_d = seed_cnt_q + CW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         seed_cnt_q  <= '0;
         out_data_q  <= '0;
         out_tap_q   <= '0;
         gen_count_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         seed_cnt_q  <= seed_cnt_d;
         if (capture) begin
            out_data_q <= z0;
            out_tap_q  <= zlast;
         end
         if (gen_inc) gen_count_q <= gen_count_q + CNT_W'(1);
      end
   end

   assign bus.seed_busy = (state_q == ST_SEED);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_tap   = out_tap_q;
   assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_lag_prng.sv
// Directed bench for lag_prng: a reference model pushes expected samples, each fire pops and compares.
module tb_lag_prng;

   localparam int W     = 32;
   localparam int N     = 4;
   localparam int CNT_W = 32;

   typedef struct packed {
      logic [W-1:0] data;
      logic [W-1:0] tap;
   } sample_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   lag_prng_if #(.W(W), .CNT_W(CNT_W)) bus ();

   lag_prng #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int               n_assert = 0;
   int               n_fail   = 0;
   sample_t          sb[$];
   logic [W-1:0]     mz[N];
   logic [CNT_W-1:0] exp_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic model_load(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
      mz[0] = a;
      mz[1] = b;
      mz[2] = c;
      mz[3] = d;
   endtask

   // Reference recurrence for the default shifts: z[N-2] ^ (z[1] << 31) ^ (z[0] >> 1).
   task automatic push_samples(input int n);
      logic [W-1:0] nz;
      for (int k = 0; k < n; k++) begin
         sb.push_back({mz[0], mz[N-1]});
         nz = mz[N-2] ^ (mz[1] << (W - 1)) ^ (mz[0] >> 1);
         for (int i = 0; i < N - 1; i++) mz[i] = mz[i+1];
         mz[N-1] = nz;
      end
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int k;
      k = 0;
      while (bus.out_valid !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check(tag, 64'(bus.out_valid), 64'd1);
   endtask

   task automatic consume(input int n);
      sample_t e;
      bus.out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
            break;
         end
         e = sb.pop_front();
         check("fire_valid", 64'(bus.out_valid), 64'd1);
         check("out_data",   64'(bus.out_data),  64'(e.data));
         check("out_tap",    64'(bus.out_tap),   64'(e.tap));
         check("gen_count",  64'(bus.gen_count), 64'(exp_cnt));
         tick();
         exp_cnt++;
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic seed_start_pulse();
      bus.seed_start = 1'b1;
      tick();
      bus.seed_start = 1'b0;
      check("seed_busy_enter", 64'(bus.seed_busy), 64'd1);
      check("seed_valid_drop", 64'(bus.out_valid), 64'd0);
   endtask

   task automatic seed_word(input logic [W-1:0] w, input int gap);
      bus.seed_valid = 1'b1;
      bus.seed_data  = w;
      tick();
      bus.seed_valid = 1'b0;
      bus.seed_data  = '0;
      for (int g = 0; g < gap; g++) begin
         check("seed_busy_gap", 64'(bus.seed_busy), 64'd1);
         tick();
      end
   endtask

   initial begin
      sample_t e;
      bus.seed_start = 1'b0;
      bus.seed_valid = 1'b0;
      bus.seed_data  = '0;
      bus.out_ready  = 1'b0;
      exp_cnt        = '0;

      // Reset values.
      repeat (3) tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data",  64'(bus.out_data),  64'd0);
      check("rst_out_tap",   64'(bus.out_tap),   64'd0);
      check("rst_gen_count", 64'(bus.gen_count), 64'd0);
      check("rst_seed_busy", 64'(bus.seed_busy), 64'd0);

      // First sample one edge after release, then backpressure holds it.
      reset = 1'b0;
      model_load(32'd364, 32'd1, 32'd2, 32'd3);
      push_samples(3);
      check("prime_not_yet", 64'(bus.out_valid), 64'd0);
      tick();
      check("valid_after_release", 64'(bus.out_valid), 64'd1);
      for (int k = 0; k < 5; k++) begin
         check("bp_data",  64'(bus.out_data),  64'(sb[0].data));
         check("bp_tap",   64'(bus.out_tap),   64'(sb[0].tap));
         check("bp_count", 64'(bus.gen_count), 64'(exp_cnt));
         tick();
      end
      consume(3);

      // Reseed with a junk word, a restart that outranks a seed word, and gapped words.
      seed_start_pulse();
      seed_word(32'd99, 1);
      bus.seed_start = 1'b1;
      bus.seed_valid = 1'b1;
      bus.seed_data  = 32'd77;
      tick();
      bus.seed_start = 1'b0;
      bus.seed_valid = 1'b0;
      check("restart_busy", 64'(bus.seed_busy), 64'd1);
      seed_word(32'd10, 1);
      seed_word(32'd20, 0);
      seed_word(32'd30, 2);
      seed_word(32'd40, 0);
      model_load(32'd10, 32'd20, 32'd30, 32'd40);
      push_samples(2);
      check("seed_done_busy", 64'(bus.seed_busy), 64'd0);
      check("prime_valid_low", 64'(bus.out_valid), 64'd0);
      tick();
      check("reseed_valid", 64'(bus.out_valid), 64'd1);
      consume(2);

      // All-zero seed falls back to the default seed.
      seed_start_pulse();
      for (int k = 0; k < N; k++) seed_word('0, 0);
      model_load(32'd364, 32'd1, 32'd2, 32'd3);
      push_samples(2);
      wait_valid("zero_seed_valid", 4);
      consume(2);

      // seed_start together with a fire: one count, no capture, then identical default sequence.
      push_samples(1);
      e = sb.pop_front();
      check("race_data", 64'(bus.out_data), 64'(e.data));
      check("race_tap",  64'(bus.out_tap),  64'(e.tap));
      bus.out_ready  = 1'b1;
      bus.seed_start = 1'b1;
      tick();
      exp_cnt++;
      bus.seed_start = 1'b0;
      check("race_count",     64'(bus.gen_count), 64'(exp_cnt));
      check("race_valid_low", 64'(bus.out_valid), 64'd0);
      check("race_busy",      64'(bus.seed_busy), 64'd1);
      check("race_data_hold", 64'(bus.out_data),  64'(e.data));
      repeat (2) tick();
      check("seed_ignores_ready", 64'(bus.gen_count), 64'(exp_cnt));
      bus.out_ready = 1'b0;
      seed_word(32'd364, 0);
      seed_word(32'd1, 0);
      seed_word(32'd2, 0);
      seed_word(32'd3, 0);
      model_load(32'd364, 32'd1, 32'd2, 32'd3);
      push_samples(3);
      wait_valid("race_reseed_valid", 4);
      consume(3);

      // Asynchronous reset in the middle of seeding.
      seed_start_pulse();
      seed_word(32'd5, 0);
      seed_word(32'd6, 0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_out_data",  64'(bus.out_data),  64'd0);
      check("arst_out_tap",   64'(bus.out_tap),   64'd0);
      check("arst_gen_count", 64'(bus.gen_count), 64'd0);
      check("arst_seed_busy", 64'(bus.seed_busy), 64'd0);
      tick();
      reset = 1'b0;
      sb.delete();
      exp_cnt = '0;
      model_load(32'd364, 32'd1, 32'd2, 32'd3);
      push_samples(2);
      check("arst_prime_low", 64'(bus.out_valid), 64'd0);
      tick();
      check("arst_valid", 64'(bus.out_valid), 64'd1);
      consume(2);

      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
